// File: rtl/npu_spm_defines.sv
// Shared scratchpad-memory definitions.
// Provides lane/bank counts, the piggyback tag width and the address,
// data and mask types that the scratchpad pipeline stages use.
package npu_spm_defines;

  localparam int unsigned SM_PROCESSING_ELEMENTS = 16;
  localparam int unsigned SM_MEMORY_BANKS        = 16;
  localparam int unsigned SM_BANK_ENTRIES        = 1024;
  localparam int unsigned SM_WORD_BYTES          = 4;
  localparam int unsigned SM_PIGGYBACK_DATA_LEN  = 8;

  typedef logic [31:0]                          sm_address_t;
  typedef logic [31:0]                          sm_data_t;
  typedef logic [SM_WORD_BYTES-1:0]             sm_byte_mask_t;
  typedef logic [$clog2(SM_MEMORY_BANKS)-1:0]   sm_bank_address_t;
  typedef logic [$clog2(SM_BANK_ENTRIES)-1:0]   sm_entry_address_t;

endpackage

// File: rtl/spm_bank_winner_select.sv
// Per-beat bank conflict resolution.
// For each bank, the lowest-indexed pending lane that targets it wins. For
// loads, other pending lanes hitting exactly the same bank entry as that
// winner ride along on the same read (broadcast); stores only satisfy winners.
// Ports:
//   i_pending          lanes still waiting for service
//   i_bank_indexes     per-lane bank index
//   i_bank_offsets     per-lane entry offset within the bank
//   i_is_store         1 = store request (no broadcast)
//   o_satisfied_mask_c lanes serviced by this beat (combinational)
module spm_bank_winner_select
  import npu_spm_defines::*;
(
  input  logic [SM_PROCESSING_ELEMENTS-1:0]              i_pending,
  input  sm_bank_address_t  [SM_PROCESSING_ELEMENTS-1:0] i_bank_indexes,
  input  sm_entry_address_t [SM_PROCESSING_ELEMENTS-1:0] i_bank_offsets,
  input  logic                                           i_is_store,
  output logic [SM_PROCESSING_ELEMENTS-1:0]              o_satisfied_mask_c
);

  // w_shadowed[l]: a lower pending lane targets the same bank, i.e. lane l
  // is not its bank's winner; w_lead_offset[l] is that winner's offset.
  logic [SM_PROCESSING_ELEMENTS-1:0]              w_shadowed;
  sm_entry_address_t [SM_PROCESSING_ELEMENTS-1:0] w_lead_offset;

  always_comb begin
    w_shadowed         = '0;
    w_lead_offset      = '0;
    o_satisfied_mask_c = '0;
    for (int l = 0; l < SM_PROCESSING_ELEMENTS; l++) begin
      for (int j = 0; j < l; j++) begin
        if (!w_shadowed[l] && i_pending[j] &&
            (i_bank_indexes[j] == i_bank_indexes[l])) begin
          w_shadowed[l]    = 1'b1;
          w_lead_offset[l] = i_bank_offsets[j];
        end
      end
      o_satisfied_mask_c[l] = i_pending[l] &&
        (!w_shadowed[l] ||
         (!i_is_store && (w_lead_offset[l] == i_bank_offsets[l])));
    end
  end

endmodule

// File: rtl/spm_conflict_scheduler.sv
// Scratchpad bank-conflict scheduler (stage 1).
// Accepts one multi-lane request in IDLE, then issues as many beats as
// needed so that no bank sees two different entries in the same beat.
// Ports:
//   clock, resetn          clock, synchronous active-low reset
//   req_*                  incoming request (valid/ready handshake)
//   sched_valid            a beat is presented to stage 2
//   sched_satisfied_mask   lanes serviced by this beat
//   sched_is_last_request  final beat of the current request
//   sched_*                remaining fields, constant for the whole request
module spm_conflict_scheduler
  import npu_spm_defines::*;
(
  input  logic                                           clock,
  input  logic                                           resetn,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic                                           req_is_store,
  input  sm_address_t       [SM_PROCESSING_ELEMENTS-1:0] req_address,
  input  sm_data_t          [SM_PROCESSING_ELEMENTS-1:0] req_write_data,
  input  sm_byte_mask_t     [SM_PROCESSING_ELEMENTS-1:0] req_byte_mask,
  input  logic              [SM_PROCESSING_ELEMENTS-1:0] req_mask,
  input  logic              [SM_PIGGYBACK_DATA_LEN-1:0]  req_piggyback_data,
  output logic                                           sched_valid,
  output logic                                           sched_is_store,
  output logic                                           sched_is_last_request,
  output sm_bank_address_t  [SM_PROCESSING_ELEMENTS-1:0] sched_bank_indexes,
  output sm_entry_address_t [SM_PROCESSING_ELEMENTS-1:0] sched_bank_offsets,
  output logic              [SM_PROCESSING_ELEMENTS-1:0] sched_satisfied_mask,
  output sm_data_t          [SM_PROCESSING_ELEMENTS-1:0] sched_write_data,
  output sm_byte_mask_t     [SM_PROCESSING_ELEMENTS-1:0] sched_byte_mask,
  output logic              [SM_PROCESSING_ELEMENTS-1:0] sched_mask,
  output logic              [SM_PIGGYBACK_DATA_LEN-1:0]  sched_piggyback_data
);

  localparam int unsigned PE         = SM_PROCESSING_ELEMENTS;
  localparam int unsigned BYTE_OFF_W = $clog2(SM_WORD_BYTES);
  localparam int unsigned BANK_W     = $bits(sm_bank_address_t);
  localparam int unsigned ENTRY_W    = $bits(sm_entry_address_t);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                                r_state;
  state_t                                w_next_state;
  logic                                  w_accept;
  logic [PE-1:0]                         r_pending;
  logic [PE-1:0]                         w_next_pending;
  logic [PE-1:0]                         w_satisfied;

  logic                                  r_is_store;
  sm_address_t   [PE-1:0]                r_address;
  sm_data_t      [PE-1:0]                r_write_data;
  sm_byte_mask_t [PE-1:0]                r_byte_mask;
  logic          [PE-1:0]                r_mask;
  logic          [SM_PIGGYBACK_DATA_LEN-1:0] r_piggyback_data;

  sm_bank_address_t  [PE-1:0]            w_bank_indexes;
  sm_entry_address_t [PE-1:0]            w_bank_offsets;

  // Bank = word-address low bits, entry = the bits directly above them.
  always_comb begin
    w_bank_indexes = '0;
    w_bank_offsets = '0;
    for (int l = 0; l < PE; l++) begin
      w_bank_indexes[l] = r_address[l][BYTE_OFF_W +: BANK_W];
      w_bank_offsets[l] = r_address[l][BYTE_OFF_W + BANK_W +: ENTRY_W];
    end
  end

  spm_bank_winner_select u_winner_select (
    .i_pending          (r_pending),
    .i_bank_indexes     (w_bank_indexes),
    .i_bank_offsets     (w_bank_offsets),
    .i_is_store         (r_is_store),
    .o_satisfied_mask_c (w_satisfied)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // Pending lanes and latched request fields.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_pending        <= '0;
      r_is_store       <= 1'b0;
      r_address        <= '0;
      r_write_data     <= '0;
      r_byte_mask      <= '0;
      r_mask           <= '0;
      r_piggyback_data <= '0;
    end else begin
      r_pending <= w_next_pending;
      if (w_accept) begin
        r_is_store       <= req_is_store;
        r_address        <= req_address;
        r_write_data     <= req_write_data;
        r_byte_mask      <= req_byte_mask;
        r_mask           <= req_mask;
        r_piggyback_data <= req_piggyback_data;
      end
    end
  end

  // Next state and outputs; every sched_* output is zero outside ISSUE.
  always_comb begin
    w_next_state          = r_state;
    w_next_pending        = r_pending;
    w_accept              = 1'b0;
    req_ready             = 1'b0;
    sched_valid           = 1'b0;
    sched_is_store        = 1'b0;
    sched_is_last_request = 1'b0;
    sched_bank_indexes    = '0;
    sched_bank_offsets    = '0;
    sched_satisfied_mask  = '0;
    sched_write_data      = '0;
    sched_byte_mask       = '0;
    sched_mask            = '0;
    sched_piggyback_data  = '0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_accept       = 1'b1;
          w_next_pending = req_mask;
          w_next_state   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        sched_valid          = 1'b1;
        sched_is_store       = r_is_store;
        sched_bank_indexes   = w_bank_indexes;
        sched_bank_offsets   = w_bank_offsets;
        sched_satisfied_mask = w_satisfied;
        sched_write_data     = r_write_data;
        sched_byte_mask      = r_byte_mask;
        sched_mask           = r_mask;
        sched_piggyback_data = r_piggyback_data;
        w_next_pending       = r_pending & ~w_satisfied;
        // An empty request still yields one (empty, last) beat.
        if (w_next_pending == '0) begin
          sched_is_last_request = 1'b1;
          w_next_state          = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_spm_conflict_scheduler.sv
// Directed bench for spm_conflict_scheduler: hand-computed beat sequences.
module tb_spm_conflict_scheduler;
  import npu_spm_defines::*;

  localparam int unsigned PE = SM_PROCESSING_ELEMENTS;

  logic                                           clock = 1'b0;
  logic                                           resetn;
  logic                                           req_valid;
  logic                                           req_ready;
  logic                                           req_is_store;
  sm_address_t       [PE-1:0]                     req_address;
  sm_data_t          [PE-1:0]                     req_write_data;
  sm_byte_mask_t     [PE-1:0]                     req_byte_mask;
  logic              [PE-1:0]                     req_mask;
  logic              [SM_PIGGYBACK_DATA_LEN-1:0]  req_piggyback_data;
  logic                                           sched_valid;
  logic                                           sched_is_store;
  logic                                           sched_is_last_request;
  sm_bank_address_t  [PE-1:0]                     sched_bank_indexes;
  sm_entry_address_t [PE-1:0]                     sched_bank_offsets;
  logic              [PE-1:0]                     sched_satisfied_mask;
  sm_data_t          [PE-1:0]                     sched_write_data;
  sm_byte_mask_t     [PE-1:0]                     sched_byte_mask;
  logic              [PE-1:0]                     sched_mask;
  logic              [SM_PIGGYBACK_DATA_LEN-1:0]  sched_piggyback_data;

  spm_conflict_scheduler dut (
    .clock                 (clock),
    .resetn                (resetn),
    .req_valid             (req_valid),
    .req_ready             (req_ready),
    .req_is_store          (req_is_store),
    .req_address           (req_address),
    .req_write_data        (req_write_data),
    .req_byte_mask         (req_byte_mask),
    .req_mask              (req_mask),
    .req_piggyback_data    (req_piggyback_data),
    .sched_valid           (sched_valid),
    .sched_is_store        (sched_is_store),
    .sched_is_last_request (sched_is_last_request),
    .sched_bank_indexes    (sched_bank_indexes),
    .sched_bank_offsets    (sched_bank_offsets),
    .sched_satisfied_mask  (sched_satisfied_mask),
    .sched_write_data      (sched_write_data),
    .sched_byte_mask       (sched_byte_mask),
    .sched_mask            (sched_mask),
    .sched_piggyback_data  (sched_piggyback_data)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  sm_address_t [PE-1:0]               t_addr;
  logic [SM_PIGGYBACK_DATA_LEN-1:0]   t_pb;
  logic [15:0]                        exp_sat[$];

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Everything zero, ready high: the state outside ISSUE.
  task automatic check_idle(input string tag);
    check_eq({tag, "_valid"}, 64'(sched_valid), 64'd1 - 64'd1);
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
    check_eq({tag, "_last"},  64'(sched_is_last_request), 64'd0);
    check_eq({tag, "_sat"},   64'(sched_satisfied_mask), 64'd0);
    check_eq({tag, "_bidx"},  64'(sched_bank_indexes), 64'd0);
    check_eq({tag, "_pb"},    64'(sched_piggyback_data), 64'd0);
  endtask

  // Offer one request at a negedge in IDLE and walk the expected beats.
  // With hold=1, req_valid stays high during ISSUE with scrambled fields.
  task automatic run_req(input string tag, input logic st,
                         input logic [15:0] mask, input logic hold);
    logic [63:0] exp_bi;
    exp_bi = '0;
    for (int i = 0; i < int'(PE); i++) exp_bi[4*i +: 4] = t_addr[i][5:2];
    req_is_store       = st;
    req_mask           = mask;
    req_address        = t_addr;
    req_piggyback_data = t_pb;
    for (int i = 0; i < int'(PE); i++) begin
      req_write_data[i] = 32'hA000_0000 + 32'(i);
      req_byte_mask[i]  = 4'hF ^ 4'(i);
    end
    req_valid = 1'b1;
    check_eq({tag, "_ready_in"}, 64'(req_ready), 64'd1);
    @(negedge clock);
    if (!hold) req_valid = 1'b0;
    else begin
      req_mask           = '0;
      req_is_store       = ~st;
      req_piggyback_data = ~t_pb;
      for (int i = 0; i < int'(PE); i++) begin
        req_address[i]    = 32'h3C;
        req_write_data[i] = '0;
      end
    end
    for (int k = 0; k < exp_sat.size(); k++) begin
      check_eq({tag, "_valid"}, 64'(sched_valid), 64'd1);
      check_eq({tag, "_ready"}, 64'(req_ready), 64'd0);
      check_eq({tag, "_sat"},   64'(sched_satisfied_mask), 64'(exp_sat[k]));
      check_eq({tag, "_last"},  64'(sched_is_last_request),
               (k == exp_sat.size() - 1) ? 64'd1 : 64'd0);
      check_eq({tag, "_mask"},  64'(sched_mask), 64'(mask));
      check_eq({tag, "_store"}, 64'(sched_is_store), 64'(st));
      check_eq({tag, "_pb"},    64'(sched_piggyback_data), 64'(t_pb));
      check_eq({tag, "_bidx"},  64'(sched_bank_indexes), exp_bi);
      check_eq({tag, "_off15"}, 64'(sched_bank_offsets[15]),
               64'(t_addr[15][15:6]));
      check_eq({tag, "_off1"},  64'(sched_bank_offsets[1]),
               64'(t_addr[1][15:6]));
      check_eq({tag, "_wd3"},   64'(sched_write_data[3]), 64'h0000_0000_A000_0003);
      check_eq({tag, "_bm5"},   64'(sched_byte_mask[5]), 64'hA);
      @(negedge clock);
    end
    req_valid = 1'b0;
    check_idle({tag, "_after"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn             = 1'b0;
    req_valid          = 1'b0;
    req_is_store       = 1'b0;
    req_address        = '0;
    req_write_data     = '0;
    req_byte_mask      = '0;
    req_mask           = '0;
    req_piggyback_data = '0;
    t_pb               = 8'h5A;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_idle("reset");
    resetn = 1'b1;
    @(negedge clock);
    check_idle("post_reset");

    // Lane i word i: sixteen distinct banks, one beat.
    for (int i = 0; i < int'(PE); i++) t_addr[i] = 32'(4 * i);
    exp_sat = {16'hFFFF};
    run_req("ld_linear", 1'b0, 16'hFFFF, 1'b0);

    // All lanes in bank 0, different entries: one lane per beat.
    for (int i = 0; i < int'(PE); i++) t_addr[i] = 32'(32'h40 * i);
    exp_sat.delete();
    for (int i = 0; i < int'(PE); i++) exp_sat.push_back(16'(1 << i));
    t_pb = 8'hC3;
    run_req("st_bank0", 1'b1, 16'hFFFF, 1'b0);

    // Same word everywhere: loads broadcast, stores serialise.
    for (int i = 0; i < int'(PE); i++) t_addr[i] = 32'h100;
    exp_sat = {16'hFFFF};
    run_req("ld_bcast", 1'b0, 16'hFFFF, 1'b0);
    exp_sat.delete();
    for (int i = 0; i < int'(PE); i++) exp_sat.push_back(16'(1 << i));
    run_req("st_same", 1'b1, 16'hFFFF, 1'b0);

    // Empty request still produces one last beat.
    for (int i = 0; i < int'(PE); i++) t_addr[i] = 32'(4 * i);
    exp_sat = {16'h0000};
    run_req("empty", 1'b0, 16'h0000, 1'b0);

    // Lanes 0 and 2 in bank 3, entries 0 and 1.
    for (int i = 0; i < int'(PE); i++) t_addr[i] = '0;
    t_addr[0] = 32'h0C;
    t_addr[2] = 32'h4C;
    exp_sat = {16'h0001, 16'h0004};
    run_req("bank3", 1'b0, 16'h0005, 1'b0);

    // Partial broadcast: lanes 0,2 share bank0/entry0, lane1 bank0/entry1,
    // lane3 bank1 -> beats 0x000D then 0x0002.
    t_addr[0] = 32'h00;
    t_addr[1] = 32'h40;
    t_addr[2] = 32'h00;
    t_addr[3] = 32'h04;
    exp_sat = {16'h000D, 16'h0002};
    run_req("mixed", 1'b0, 16'h000F, 1'b0);

    // req_valid held high with other data during ISSUE is ignored.
    t_pb = 8'h81;
    exp_sat = {16'h000D, 16'h0002};
    run_req("hold", 1'b0, 16'h000F, 1'b1);

    // Reset during the third beat of the bank-0 store.
    for (int i = 0; i < int'(PE); i++) t_addr[i] = 32'(32'h40 * i);
    req_is_store = 1'b1;
    req_mask     = 16'hFFFF;
    req_address  = t_addr;
    req_valid    = 1'b1;
    @(negedge clock);
    req_valid = 1'b0;
    check_eq("rst_b1", 64'(sched_satisfied_mask), 64'h1);
    @(negedge clock);
    check_eq("rst_b2", 64'(sched_satisfied_mask), 64'h2);
    @(negedge clock);
    check_eq("rst_b3", 64'(sched_satisfied_mask), 64'h4);
    check_eq("rst_b3_valid", 64'(sched_valid), 64'd1);
    resetn = 1'b0;
    @(negedge clock);
    check_eq("rst_valid", 64'(sched_valid), 64'd0);
    check_eq("rst_last",  64'(sched_is_last_request), 64'd0);
    resetn = 1'b1;
    @(negedge clock);
    check_idle("rst_release");

    // Scheduler is usable again after the abandoned request.
    for (int i = 0; i < int'(PE); i++) t_addr[i] = 32'(4 * i);
    exp_sat = {16'hFFFF};
    run_req("after_rst", 1'b0, 16'hFFFF, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_conflict_scheduler.md
SPM_CONFLICT_SCHEDULER -- requirements
Module: spm_conflict_scheduler

Interface
REQ-001 SHALL have ports clock (input, 1) and resetn (input, 1); one clock, reset synchronous and active-low.
REQ-002 SHALL have ports req_valid (input, 1), req_ready (output, 1): request handshake, transfer when both high at posedge clock.
REQ-003 SHALL have port req_is_store (input, 1): 1 = store, 0 = load.
REQ-004 SHALL have ports req_address (input, SM_PROCESSING_ELEMENTS x sm_address_t), req_write_data (input, PE x sm_data_t), req_byte_mask (input, PE x sm_byte_mask_t), req_mask (input, PE): per-lane request fields.
REQ-005 SHALL have port req_piggyback_data (input, SM_PIGGYBACK_DATA_LEN): opaque tag.
REQ-006 SHALL have port sched_valid (output, 1): a beat is presented to stage 2 this cycle.
REQ-007 SHALL have ports sched_is_store, sched_is_last_request (output, 1 each); sched_bank_indexes (PE x sm_bank_address_t), sched_bank_offsets (PE x sm_entry_address_t), sched_satisfied_mask (PE), sched_write_data, sched_byte_mask, sched_mask (PE), sched_piggyback_data (outputs): per-beat stage-2 request.

Function
REQ-008 SHALL implement states IDLE and ISSUE; req_ready = 1 only in IDLE.
REQ-009 SHALL, on handshake in IDLE, latch all req_* fields, set pending = req_mask, enter ISSUE next cycle.
REQ-010 SHALL derive per lane: bank index = word-address low bits (address bits above byte offset, width of sm_bank_address_t); bank offset = next sm_entry_address_t bits.
REQ-011 SHALL, each ISSUE cycle, for each bank select the lowest-indexed pending lane targeting it as winner.
REQ-012 SHALL, for loads only, also satisfy pending lanes with identical bank and offset to that bank's winner (broadcast); stores satisfy winners only.
REQ-013 SHALL drive sched_valid = 1 and sched_satisfied_mask = lanes satisfied this beat (per-beat, not cumulative) throughout ISSUE.
REQ-014 SHALL update pending <= pending & ~sched_satisfied_mask each ISSUE cycle.
REQ-015 SHALL assert sched_is_last_request when pending & ~sched_satisfied_mask == 0; return to IDLE next cycle.
REQ-016 SHALL, for req_mask == 0, issue exactly one beat with satisfied mask 0 and sched_is_last_request = 1.
REQ-017 SHALL hold sched_is_store, sched_bank_indexes, sched_bank_offsets, sched_write_data, sched_byte_mask, sched_mask (= latched req_mask), sched_piggyback_data constant across all beats of a request.
REQ-018 SHALL drive every sched_* output to 0 in IDLE.
REQ-019 SHALL produce first beat one cycle after handshake; beat count = max number of distinct (for loads) lanes per bank; minimum idle gap between requests = 1 cycle (ISSUE->IDLE).
REQ-020 SHALL ignore req_valid and all req_* inputs while in ISSUE.
REQ-021 SHALL not accept backpressure; downstream pipeline always consumes a beat.

Reset
REQ-022 SHALL, with resetn low at posedge clock, enter IDLE, clear pending and latched fields; all outputs 0 except req_ready = 1 from the following cycle.
REQ-023 SHALL abandon an in-flight request on reset mid-ISSUE with no further beats and no sched_is_last_request.

Structure
REQ-024 SHALL take sm_address_t, sm_bank_address_t, sm_entry_address_t, sm_data_t, sm_byte_mask_t, SM_PROCESSING_ELEMENTS, SM_MEMORY_BANKS, SM_PIGGYBACK_DATA_LEN from the shared npu_spm_defines package; no new package types.
REQ-025 SHALL place winner/broadcast selection in one combinational sub-module spm_bank_winner_select (pending, bank indexes, offsets, is_store -> satisfied mask).

Verification (PE = 16, banks = 16, 4-byte words)
REQ-026 Load, lane i address 4*i, mask 0xFFFF -> 1 beat, satisfied 0xFFFF, last = 1, back to IDLE next cycle.
REQ-027 Store, all lanes address 0x40*i (all bank 0) -> 16 beats, satisfied 0x0001, 0x0002 ... 0x8000, last only on beat 16.
REQ-028 Load, all lanes address 0x100 -> 1 beat satisfied 0xFFFF (broadcast); same as store -> 16 beats.
REQ-029 req_mask = 0x0000 -> 1 beat, satisfied 0, last = 1; req_mask = 0x0005, lanes 0,2 both bank 3 different offsets -> beats 0x0001 then 0x0004.
REQ-030 resetn low during beat 3 of REQ-027 -> next cycle sched_valid = 0, req_ready = 1 after reset release, no last beat.
REQ-031 req_valid held high during ISSUE with different data -> ignored; accepted only in IDLE; first beat exactly one cycle after handshake.
